// File: rtl/instr_loader.sv
// Boot-time program loader: assembles little-endian words from a byte stream
// and writes them to consecutive instruction memory addresses while holding the core.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 1024,
    parameter int DIR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8:0]            word_count,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [DIR_WIDTH-1:0]  dir,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold,
    output logic [1:0]            dbg_state_o
);

    localparam logic [8:0] CAP_WORDS = 9'(MEM_DEPTH / 4);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [8:0]            count_q, count_d;
    logic [8:0]            widx_q,  widx_d;
    logic [1:0]            bidx_q,  bidx_d;
    logic [DATA_WIDTH-1:0] asm_q,   asm_d;
    logic                  err_q,   err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        err_d   = err_q;
        case (state_q)
            // DONE shares the start decision with IDLE so a reload needs no extra cycle
            IDLE, DONE: begin
                if (start) begin
                    if (word_count == 9'd0) begin
                        state_d = DONE;
                        err_d   = 1'b0;
                    end else if (word_count > CAP_WORDS) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        count_d = word_count;
                        widx_d  = '0;
                        bidx_d  = '0;
                        err_d   = 1'b0;
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bidx_q == 2'(k)) begin
                            asm_d[k*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
                        end
                    end
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                widx_d  = widx_q + 9'd1;
                state_d = (widx_d == count_q) ? DONE : COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset drops we immediately
    always_comb begin
        byte_ready  = (state_q == COLLECT);
        we          = (state_q == WRITE);
        busy        = (state_q == COLLECT) || (state_q == WRITE);
        done        = (state_q == DONE);
        err         = err_q;
        cpu_hold    = !((state_q == DONE) && !err_q);
        dir         = DIR_WIDTH'({widx_q, 2'b00});
        data_in     = asm_q;
        dbg_state_o = state_q;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader sitting directly upstream of `instruction_memory`. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the memory's write port (`dir`, `data_in`, `we`) at consecutive byte addresses 0, 4, 8, …. The core is held via `cpu_hold` until the requested number of words has been written.

## Interface
- `DATA_WIDTH`, default 32: instruction word width; must match `instruction_memory`.
- `BYTE_WIDTH`, default 8: stream byte width.
- `MEM_DEPTH`, default 1024: memory size in bytes; capacity is MEM_DEPTH/4 = 256 words.
- `DIR_WIDTH`, default 10: width of the memory write byte address, clog2(MEM_DEPTH).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `word_count`  in  9  number of words to load, 0..256; sampled on the `start` cycle.
- `byte_in`  in  BYTE_WIDTH  stream data.
- `byte_valid`  in  1  stream data valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `dir`  out  DIR_WIDTH  memory write byte address; connects to `instruction_memory.dir`.
- `data_in`  out  DATA_WIDTH  memory write data.
- `we`  out  1  memory write enable; one-cycle pulse per word.
- `busy`  out  1  high in COLLECT and WRITE.
- `done`  out  1  high in DONE.
- `err`  out  1  `word_count` exceeded capacity on the last start.
- `cpu_hold`  out  1  keeps the core in reset; low only in DONE with `err`=0.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: `byte_ready`=0. On `start`:
  - `word_count`=0 → DONE with no writes.
  - `word_count`>256 → DONE with `err`=1 and no writes.
  - Otherwise, latch the count, clear word index and byte index, clear `err`, go to COLLECT.
- COLLECT: `byte_ready`=1.
  - A byte transfers on any edge where `byte_valid`&&`byte_ready`.
  - Byte k (k=0..3) goes to bits [8k+7:8k], so the first byte is the LSB.
  - Byte index increments modulo 4.
  - Acceptance of byte 3 → WRITE.
  - `byte_valid` low simply stalls; there is no timeout.
- WRITE: `byte_ready`=0, `we`=1, `dir`=word_index*4, `data_in`=assembled word.
  - Word index increments at the end of the cycle.
  - If the new index equals the latched count → DONE, else → COLLECT.
- DONE: `done`=1. `cpu_hold`=`err`. A `start` pulse re-enters the IDLE start decision in the same cycle, allowing a reload.
- `start` in COLLECT or WRITE is ignored.
- Word index is 9 bits. `dir` = {index[7:0], 2'b00}, so the address never wraps within a legal load; the last legal `dir` is 0x3FC.
- The assembly register is not cleared between words. Every word is fully overwritten by 4 bytes before WRITE.

## Timing
- Reset values: `byte_ready`=0, `dir`=0, `data_in`=0, `we`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1; state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byte_valid` to `byte_ready`.
- `start` at edge N → `busy`=1 and `byte_ready`=1 in cycle N+1.
- 4th byte accepted at edge M:
  - `we`=1 for exactly cycle M+1; memory captures at edge M+2.
  - `byte_ready` is back to 1 in cycle M+2.
- Throughput is at least 5 cycles per word (4 byte cycles + 1 write cycle).
- Final WRITE cycle at cycle W → `done`=1, `busy`=0, `cpu_hold`=0 from cycle W+1.
- Zero-count or error start at edge N → `done`=1 in cycle N+1; `we` never asserts.
- Reset mid-operation (any state): immediate return to reset values, partial word discarded, `we` deasserted asynchronously, no spurious write.

## Test plan
- Load the 10-word Fibonacci program (0x00000513, 0x00100593, 0x00A00613, 0x00060C63, 0x00B502B3, 0x00B00533, 0x005005B3, 0xFFF60613, 0xFEDFF06F, 0x0000006F) with `byte_valid` held high. Required: 10 `we` pulses at `dir`=0x00..0x24. Reading `a`=0x00 gives 0x00000513 and `a`=0x24 gives 0x0000006F. `done`=1 and `cpu_hold`=0 at cycle start+51.
- Same program with random `byte_valid` gaps of 0-7 cycles. Required: identical memory contents, and `we` never high in two consecutive cycles.
- `word_count`=0 → `done`=1 one cycle after `start`, `err`=0, zero writes.
- `word_count`=300 → `err`=1, `done`=1, `cpu_hold`=1, zero writes. A following `start` with count 1 clears `err`.
- Assert `rst` after 2 bytes of word 3. Required: outputs at reset values, and the memory write count stays at 3. A subsequent full reload succeeds.
- `word_count`=256 with incrementing byte pattern → last write has `dir`=0x3FC and `data_in`=0xFFFEFDFC (low byte 0xFC first). `done` asserts only after that write.
